// File: rtl/seven_seg_scanner.sv
// Time-multiplexed hex driver for an active-LOW seven-segment bank.
// Inputs are shadowed once per frame; each slot opens with an anode dead-time.
module seven_seg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_HZ      = 100_000_000,
  parameter int REFRESH_HZ  = 1000,
  parameter int DEAD_CYCLES = 1000,
  parameter int BLINK_HZ    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int ND_SAFE     = (NUM_DIGITS < 1) ? 1 : NUM_DIGITS;
  localparam int SLOT_CYCLES = CLK_HZ / (REFRESH_HZ * ND_SAFE);
  localparam int BLINK_HALF  = CLK_HZ / (2 * BLINK_HZ);
  localparam int SW          = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int BW          = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int DW          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] DEAD_LIM   = SW'(DEAD_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("seven_seg_scanner: NUM_DIGITS must be in 1..8");
    end
    if (DEAD_CYCLES < 1 || SLOT_CYCLES <= DEAD_CYCLES) begin : g_bad_dead
      $error("seven_seg_scanner: need 1 <= DEAD_CYCLES < SLOT_CYCLES");
    end
    if (BLINK_HALF < 1) begin : g_bad_blink
      $error("seven_seg_scanner: BLINK_HZ too high for CLK_HZ");
    end
  endgenerate

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  logic [SW-1:0]           r_slot_cnt;
  logic [BW-1:0]           r_blink_cnt;
  logic                    r_blink_phase;
  logic                    r_frame_tick;
  logic [4*NUM_DIGITS-1:0] r_sh_value;
  logic [NUM_DIGITS-1:0]   r_sh_blank;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_blink;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp_n;

  logic [DW-1:0]           w_digit_idx;
  logic                    w_slot_wrap;
  logic                    w_frame_start;
  logic [NUM_DIGITS-1:0]   w_sel;
  logic [3:0]              w_nib_masked [NUM_DIGITS];
  logic [3:0]              w_nib;
  logic                    w_dead;
  logic [NUM_DIGITS-1:0]   w_hide;
  logic                    w_off;
  logic [NUM_DIGITS-1:0]   w_an_next;
  logic [6:0]              w_seg_next;
  logic                    w_dp_n_next;

  assign w_slot_wrap   = (r_slot_cnt == SLOT_LAST);
  assign w_frame_start = (r_slot_cnt == '0) && (w_digit_idx == '0);

  generate
    if (NUM_DIGITS > 1) begin : g_digit_cnt
      localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
      logic [DW-1:0] r_digit_idx;

      // Explicit terminal compare keeps the index in range for non-power-of-2 banks.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_digit_idx <= '0;
        end else if (w_slot_wrap) begin
          r_digit_idx <= (r_digit_idx == DIGIT_LAST) ? '0 : r_digit_idx + 1'b1;
        end
      end
      assign w_digit_idx = r_digit_idx;
    end else begin : g_digit_fixed
      assign w_digit_idx = '0;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_sel[gi]        = (w_digit_idx == DW'(gi));
      assign w_nib_masked[gi] = w_sel[gi] ? r_sh_value[4*gi +: 4] : 4'h0;
    end
  endgenerate

  always_comb begin
    w_nib = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_nib = w_nib | w_nib_masked[i];
    end
    w_dead      = (r_slot_cnt < DEAD_LIM);
    w_hide      = w_sel & (r_sh_blank | (r_sh_blink & {NUM_DIGITS{~r_blink_phase}}));
    w_off       = w_dead | (|w_hide);
    w_an_next   = w_off ? '1 : ~w_sel;
    w_seg_next  = w_off ? 7'h7F : glyph(w_nib);
    w_dp_n_next = w_off ? 1'b1 : ~(|(w_sel & r_sh_dp));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_cnt    <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
      r_frame_tick  <= 1'b0;
      r_sh_value    <= '0;
      r_sh_blank    <= '1;
      r_sh_dp       <= '0;
      r_sh_blink    <= '0;
      r_an          <= '1;
      r_seg         <= 7'h7F;
      r_dp_n        <= 1'b1;
    end else begin
      r_slot_cnt <= w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
      // Blink timebase is free-running and independent of the scan position.
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
      r_frame_tick <= w_frame_start;
      if (w_frame_start) begin
        r_sh_value <= value;
        r_sh_blank <= blank;
        r_sh_dp    <= dp;
        r_sh_blink <= blink;
      end
      r_an   <= w_an_next;
      r_seg  <= w_seg_next;
      r_dp_n <= w_dp_n_next;
    end
  end

  assign seg        = r_seg;
  assign dp_n       = r_dp_n;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: a frame-level reference model pushes the expected
// outputs of every cycle into a scoreboard that the scenario tasks pop and compare.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0000;
  logic [3:0]  blank = 4'h0;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  blink = 4'h0;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  seven_seg_scanner #(
    .NUM_DIGITS (4),
    .CLK_HZ     (800),
    .REFRESH_HZ (50),
    .DEAD_CYCLES(1),
    .BLINK_HZ   (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .blank     (blank),
    .dp        (dp),
    .blink     (blink),
    .seg       (seg),
    .dp_n      (dp_n),
    .an        (an),
    .frame_tick(frame_tick)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       ft;
    int         c;
  } exp_t;

  exp_t sb[$];

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: k counts cycles since reset release; slot, digit and blink
  // phase are derived arithmetically from k rather than from separate counters.
  int          m_k = 0;
  logic [15:0] m_val = 16'h0000;
  logic [3:0]  m_blank = 4'hF;
  logic [3:0]  m_dp = 4'h0;
  logic [3:0]  m_blink = 4'h0;

  initial begin
    exp_t e;
    int   slot;
    int   dig;
    bit   vis;
    bit   off;
    forever begin
      @(posedge clk);
      if (rst) begin
        e.an = 4'hF; e.seg = 7'h7F; e.dp_n = 1'b1; e.ft = 1'b0; e.c = -1;
        m_k = 0; m_val = 16'h0000; m_blank = 4'hF; m_dp = 4'h0; m_blink = 4'h0;
      end else begin
        slot = m_k % 4;
        dig  = (m_k / 4) % 4;
        vis  = ((m_k / 40) % 2) == 0;
        off  = (slot < 1) || m_blank[dig] || (m_blink[dig] && !vis);
        e.an   = off ? 4'hF : ~(4'b0001 << dig);
        e.seg  = off ? 7'h7F : glyph_tab[m_val[4*dig +: 4]];
        e.dp_n = off ? 1'b1 : ~m_dp[dig];
        e.ft   = (m_k % 16) == 0;
        e.c    = m_k + 1;
        if ((m_k % 16) == 0) begin
          m_val = value; m_blank = blank; m_dp = dp; m_blink = blink;
        end
        m_k++;
      end
      sb.push_back(e);
    end
  end

  task automatic advance(output exp_t e, output bit got);
    @(negedge clk);
    got = (sb.size() > 0);
    if (got) begin
      e = sb.pop_front();
    end else begin
      e.an = 4'hF; e.seg = 7'h7F; e.dp_n = 1'b1; e.ft = 1'b0; e.c = -2;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    bit   got;
    rst = 1'b1; value = 16'h0123; blank = 4'h0; dp = 4'h0; blink = 4'h0;
    for (int i = 0; i < 3; i++) begin
      advance(e, got);
      n_checks++;
      if (!got || an !== e.an || seg !== e.seg || dp_n !== e.dp_n || frame_tick !== e.ft) begin
        n_errors++;
        $display("FAIL reset sb c%0d: got an=%b seg=%h dp_n=%b tick=%b, want an=%b seg=%h dp_n=%b tick=%b (queued=%0d)",
                 e.c, an, seg, dp_n, frame_tick, e.an, e.seg, e.dp_n, e.ft, got);
      end
      n_checks++;
      if (an !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1 || frame_tick !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_values: got an=%b seg=%h dp_n=%b tick=%b, want an=1111 seg=7f dp_n=1 tick=0",
                 an, seg, dp_n, frame_tick);
      end
    end
    rst = 1'b0;
    advance(e, got);
    n_checks++;
    if (!got || an !== e.an || seg !== e.seg || dp_n !== e.dp_n || frame_tick !== e.ft) begin
      n_errors++;
      $display("FAIL reset sb c%0d: got an=%b seg=%h dp_n=%b tick=%b, want an=%b seg=%h dp_n=%b tick=%b",
               e.c, an, seg, dp_n, frame_tick, e.an, e.seg, e.dp_n, e.ft);
    end
    n_checks++;
    if (frame_tick !== 1'b1 || an !== 4'hF) begin
      n_errors++;
      $display("FAIL first_frame_tick c1: got tick=%b an=%b, want tick=1 an=1111", frame_tick, an);
    end
  endtask

  task automatic test_scan();
    exp_t e;
    bit   got;
    for (int i = 0; i < 5; i++) begin
      advance(e, got);
      n_checks++;
      if (!got || an !== e.an || seg !== e.seg || dp_n !== e.dp_n || frame_tick !== e.ft) begin
        n_errors++;
        $display("FAIL scan sb c%0d: got an=%b seg=%h dp_n=%b tick=%b, want an=%b seg=%h dp_n=%b tick=%b",
                 e.c, an, seg, dp_n, frame_tick, e.an, e.seg, e.dp_n, e.ft);
      end
      if (e.c == 2 || e.c == 6 || e.c == 5) begin
        logic [3:0] want_an;
        logic [6:0] want_seg;
        want_an  = (e.c == 2) ? 4'b1110 : (e.c == 6) ? 4'b1101 : 4'b1111;
        want_seg = (e.c == 2) ? 7'h30 : (e.c == 6) ? 7'h24 : 7'h7F;
        n_checks++;
        if (an !== want_an || seg !== want_seg) begin
          n_errors++;
          $display("FAIL scan_fixed c%0d: got an=%b seg=%h, want an=%b seg=%h", e.c, an, seg, want_an, want_seg);
        end
      end
    end
  endtask

  task automatic test_tear_free();
    exp_t e;
    bit   got;
    value = 16'hF8AE;
    for (int i = 0; i < 27; i++) begin
      advance(e, got);
      n_checks++;
      if (!got || an !== e.an || seg !== e.seg || dp_n !== e.dp_n || frame_tick !== e.ft) begin
        n_errors++;
        $display("FAIL tear sb c%0d: got an=%b seg=%h dp_n=%b tick=%b, want an=%b seg=%h dp_n=%b tick=%b",
                 e.c, an, seg, dp_n, frame_tick, e.an, e.seg, e.dp_n, e.ft);
      end
      if (e.c == 10 || e.c == 14 || e.c == 16 || e.c == 18 || e.c == 22 || e.c == 26 || e.c == 30) begin
        logic [3:0] want_an;
        logic [6:0] want_seg;
        case (e.c)
          10:      begin want_an = 4'b1011; want_seg = 7'h79; end
          14, 16:  begin want_an = 4'b0111; want_seg = 7'h40; end
          18:      begin want_an = 4'b1110; want_seg = 7'h06; end
          22:      begin want_an = 4'b1101; want_seg = 7'h08; end
          26:      begin want_an = 4'b1011; want_seg = 7'h00; end
          default: begin want_an = 4'b0111; want_seg = 7'h0E; end
        endcase
        n_checks++;
        if (an !== want_an || seg !== want_seg) begin
          n_errors++;
          $display("FAIL tear_fixed c%0d: got an=%b seg=%h, want an=%b seg=%h", e.c, an, seg, want_an, want_seg);
        end
      end
      if (e.c == 17) begin
        n_checks++;
        if (frame_tick !== 1'b1) begin
          n_errors++;
          $display("FAIL tear_tick c17: got tick=%b, want 1", frame_tick);
        end
      end
    end
  endtask

  task automatic test_masks();
    exp_t e;
    bit   got;
    int   an1_low = 0;
    int   dp_low = 0;
    int   dp_wrong_digit = 0;
    blank = 4'b0010; dp = 4'b0001;
    for (int i = 0; i < 48; i++) begin
      advance(e, got);
      n_checks++;
      if (!got || an !== e.an || seg !== e.seg || dp_n !== e.dp_n || frame_tick !== e.ft) begin
        n_errors++;
        $display("FAIL masks sb c%0d: got an=%b seg=%h dp_n=%b tick=%b, want an=%b seg=%h dp_n=%b tick=%b",
                 e.c, an, seg, dp_n, frame_tick, e.an, e.seg, e.dp_n, e.ft);
      end
      if (e.c >= 50) begin
        if (an[1] === 1'b0) an1_low++;
        if (dp_n === 1'b0) dp_low++;
        if (dp_n === 1'b0 && an !== 4'b1110) dp_wrong_digit++;
      end
    end
    n_checks++;
    if (an1_low !== 0) begin
      n_errors++;
      $display("FAIL blank_digit1: got %0d cycles with an[1] low, want 0", an1_low);
    end
    n_checks++;
    if (dp_low !== 6 || dp_wrong_digit !== 0) begin
      n_errors++;
      $display("FAIL dp_digit0: got %0d dp cycles (%0d off digit0), want 6 (0)", dp_low, dp_wrong_digit);
    end
  endtask

  task automatic test_blink();
    exp_t e;
    bit   got;
    int   d3_lit = 0;
    int   d0_lit = 0;
    blank = 4'h0; dp = 4'h0; blink = 4'b1000;
    for (int i = 0; i < 99; i++) begin
      advance(e, got);
      n_checks++;
      if (!got || an !== e.an || seg !== e.seg || dp_n !== e.dp_n || frame_tick !== e.ft) begin
        n_errors++;
        $display("FAIL blink sb c%0d: got an=%b seg=%h dp_n=%b tick=%b, want an=%b seg=%h dp_n=%b tick=%b",
                 e.c, an, seg, dp_n, frame_tick, e.an, e.seg, e.dp_n, e.ft);
      end
      if (e.c >= 98) begin
        if (an === 4'b0111) d3_lit++;
        if (an === 4'b1110) d0_lit++;
      end
    end
    n_checks++;
    if (d3_lit !== 6) begin
      n_errors++;
      $display("FAIL blink_digit3: got %0d lit cycles, want 6", d3_lit);
    end
    n_checks++;
    if (d0_lit !== 18) begin
      n_errors++;
      $display("FAIL blink_digit0_unaffected: got %0d lit cycles, want 18", d0_lit);
    end
  endtask

  task automatic test_midscan_reset();
    exp_t e;
    bit   got;
    bit   found = 1'b0;
    blink = 4'h0;
    for (int i = 0; i < 40 && !found; i++) begin
      advance(e, got);
      n_checks++;
      if (!got || an !== e.an || seg !== e.seg || dp_n !== e.dp_n || frame_tick !== e.ft) begin
        n_errors++;
        $display("FAIL midrst sb c%0d: got an=%b seg=%h dp_n=%b tick=%b, want an=%b seg=%h dp_n=%b tick=%b",
                 e.c, an, seg, dp_n, frame_tick, e.an, e.seg, e.dp_n, e.ft);
      end
      if (e.an === 4'b1011) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL midrst_wait: got no digit2 slot within 40 cycles, want one");
    end
    value = 16'h00C7;
    rst = 1'b1;
    advance(e, got);
    rst = 1'b0;
    n_checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1 || frame_tick !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_values: got an=%b seg=%h dp_n=%b tick=%b, want an=1111 seg=7f dp_n=1 tick=0",
               an, seg, dp_n, frame_tick);
    end
    for (int i = 0; i < 20; i++) begin
      advance(e, got);
      n_checks++;
      if (!got || an !== e.an || seg !== e.seg || dp_n !== e.dp_n || frame_tick !== e.ft) begin
        n_errors++;
        $display("FAIL midrst sb c%0d: got an=%b seg=%h dp_n=%b tick=%b, want an=%b seg=%h dp_n=%b tick=%b",
                 e.c, an, seg, dp_n, frame_tick, e.an, e.seg, e.dp_n, e.ft);
      end
      if (e.c == 1 || e.c == 2 || e.c == 6) begin
        logic [3:0] want_an;
        logic [6:0] want_seg;
        want_an  = (e.c == 1) ? 4'b1111 : (e.c == 2) ? 4'b1110 : 4'b1101;
        want_seg = (e.c == 1) ? 7'h7F : (e.c == 2) ? 7'h78 : 7'h46;
        n_checks++;
        if (an !== want_an || seg !== want_seg) begin
          n_errors++;
          $display("FAIL midrst_fixed c%0d: got an=%b seg=%h, want an=%b seg=%h", e.c, an, seg, want_an, want_seg);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tear_free();
    test_masks();
    test_blink();
    test_midscan_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
